tisc_wb_regs: RTL and testbench

WISHBONE classic slave that terminates the `tisc` master port of the TISC interconnect and implements the TISC control/status register bank. It provides:
- ident and version words
- a scratch register
- a run/clear control register
- a cycle counter with sticky overflow
- an external event counter

Every access is answered with a registered single-cycle `ack_o` or `err_o`.

---
 rtl/tisc_wb_regs.sv | 178 +++++++++++++++++
 tb/tb_tisc_wb_regs.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tisc_wb_regs.sv
// tisc_wb_regs: WISHBONE classic slave holding the TISC control/status
// register bank (ident, version, scratch, control, cycle counter with sticky
// overflow, synchronized external event counter). Every access terminates
// with a registered single-cycle ack_o, or err_o for the unmapped word.
module tisc_wb_regs #(
  parameter logic [31:0] IDENT   = 32'h54495343,
  parameter logic [31:0] VERSION = 32'h00010000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  input  logic        event_i,
  output logic        run_o
);

  localparam logic [2:0] W_ID      = 3'd0;
  localparam logic [2:0] W_VERSION = 3'd1;
  localparam logic [2:0] W_SCRATCH = 3'd2;
  localparam logic [2:0] W_CONTROL = 3'd3;
  localparam logic [2:0] W_CYCLES  = 3'd4;
  localparam logic [2:0] W_EVENTS  = 3'd5;
  localparam logic [2:0] W_STATUS  = 3'd6;
  localparam logic [2:0] W_UNMAP   = 3'd7;

  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dat;
  logic [31:0] r_scratch;
  logic        r_run;
  logic [31:0] r_cycles;
  logic        r_ovf;
  logic [31:0] r_events;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_prev;

  logic [2:0]  w_word;
  logic        w_req;
  logic        w_wr;
  logic        w_unmapped;
  logic        w_ctrl_wr;
  logic        w_cclr;
  logic        w_eclr;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_event_edge;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Byte-offset bits within a word carry no meaning for this bank.
  assign w_unused = ^adr_i[1:0];

  // Request decode: a new request is only taken once the previous
  // termination has retired, giving at most one access per two clocks.
  always_comb begin
    w_word       = adr_i[4:2];
    w_req        = cyc_i & stb_i & ~r_ack & ~r_err;
    w_unmapped   = (w_word == W_UNMAP);
    w_wr         = w_req & we_i;
    w_ctrl_wr    = w_wr & (w_word == W_CONTROL) & sel_i[0];
    w_cclr       = w_ctrl_wr & dat_i[1];
    w_eclr       = w_ctrl_wr & dat_i[2];
    w_ovf_clr    = w_wr & (w_word == W_STATUS) & sel_i[0] & dat_i[1];
    // A clear of CYCLES in the wrapping clock suppresses the overflow.
    w_ovf_set    = r_run & ~w_cclr & (r_cycles == '1);
    w_event_edge = r_sync2 & ~r_sync_prev;
  end

  // Read-data mux; reads always return the full word regardless of sel_i.
  always_comb begin
    w_rdata = '0;
    case (w_word)
      W_ID:      w_rdata = IDENT;
      W_VERSION: w_rdata = VERSION;
      W_SCRATCH: w_rdata = r_scratch;
      W_CONTROL: w_rdata = {31'd0, r_run};
      W_CYCLES:  w_rdata = r_cycles;
      W_EVENTS:  w_rdata = r_events;
      W_STATUS:  w_rdata = {30'd0, r_ovf, r_sync2};
      default:   w_rdata = '0;
    endcase
  end

  // Bus termination: load ack/err and read data, self-clear next clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req & ~w_unmapped;
      r_err <= w_req & w_unmapped;
      r_dat <= (w_req & ~we_i & ~w_unmapped) ? w_rdata : '0;
    end
  end

  // Scratch register with per-byte-lane writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scratch <= '0;
    end else if (w_wr && (w_word == W_SCRATCH)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sel_i[i]) r_scratch[8*i +: 8] <= dat_i[8*i +: 8];
      end
    end
  end

  // RUN control bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_run <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_run <= dat_i[0];
    end
  end

  // Cycle counter: clear beats increment; wraps freely.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cycles <= '0;
    end else if (w_cclr) begin
      r_cycles <= '0;
    end else if (r_run) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  // Sticky overflow: a set in the same clock wins over a write-1 clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync1     <= event_i;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  // Event counter: clear beats an edge; saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_events <= '0;
    end else if (w_eclr) begin
      r_events <= '0;
    end else if (w_event_edge && (r_events != '1)) begin
      r_events <= r_events + 32'd1;
    end
  end

  assign ack_o = r_ack;
  assign err_o = r_err;
  assign dat_o = r_dat;
  assign rty_o = 1'b0;
  assign run_o = r_run;

endmodule

// File: tb/tb_tisc_wb_regs.sv
// Directed testbench for tisc_wb_regs with hand-computed expectations.
module tb_tisc_wb_regs;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [4:0]  adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;
  logic        event_i;
  logic        run_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  tisc_wb_regs #(
    .IDENT  (32'h54495343),
    .VERSION(32'h00010000)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .cyc_i  (cyc_i),
    .stb_i  (stb_i),
    .we_i   (we_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .sel_i  (sel_i),
    .dat_o  (dat_o),
    .ack_o  (ack_o),
    .err_o  (err_o),
    .rty_o  (rty_o),
    .event_i(event_i),
    .run_o  (run_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One access, entered and left at a falling edge. Returns the sampled
  // termination and data, plus the ack/err state one cycle later.
  task automatic wb(input logic w, input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd,
                    output logic ak, output logic er, output logic term_after);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d; sel_i = s;
    @(posedge clk_i); @(negedge clk_i);
    ak = ack_o; er = err_o; rd = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    term_after = ack_o | err_o;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic ak, er, ta;
    wb(1'b0, a, 32'h0, 4'h0, rd, ak, er, ta);
    check({tag, "_data"}, rd, exp);
    check({tag, "_ack"}, {31'd0, ak}, 32'd1);
    check({tag, "_err"}, {31'd0, er}, 32'd0);
    check({tag, "_single"}, {31'd0, ta}, 32'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; logic ak, er, ta;
    wb(1'b1, a, d, s, rd, ak, er, ta);
    check("wr_ack", {31'd0, ak}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; logic ak, er, ta;
    int unsigned terms;
    rst_n_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0; event_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_run", {31'd0, run_o}, 32'd0);
    check("rst_rty", {31'd0, rty_o}, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Ident words and scratch reset value; byte offset bits ignored.
    rd_chk("id", 5'h00, 32'h54495343);
    rd_chk("ver", 5'h04, 32'h00010000);
    rd_chk("scr0", 5'h08, 32'h00000000);
    rd_chk("id_off3", 5'h03, 32'h54495343);

    // Scratch byte lanes, sel=0 write, RO write ignored.
    wr(5'h08, 32'hDEADBEEF, 4'b1111);
    wr(5'h08, 32'h00000000, 4'b0101);
    rd_chk("scr_lane", 5'h08, 32'hDE00BE00);
    wr(5'h08, 32'hFFFFFFFF, 4'b0000);
    rd_chk("scr_sel0", 5'h08, 32'hDE00BE00);
    wr(5'h00, 32'h12345678, 4'b1111);
    rd_chk("id_ro", 5'h00, 32'h54495343);

    // RUN set at edge E0; counting from E0+1. After the task and 10 more
    // clocks CYCLES=11, which the read returns (value before its edge).
    wr(5'h0C, 32'h1, 4'b0001);
    check("run_on", {31'd0, run_o}, 32'd1);
    repeat (10) @(negedge clk_i);
    rd_chk("cyc11", 5'h10, 32'd11);
    wr(5'h0C, 32'h3, 4'b0001);
    rd_chk("cyc_restart", 5'h10, 32'd1);
    rd_chk("ctrl_rd", 5'h0C, 32'h1);
    check("run_kept", {31'd0, run_o}, 32'd1);

    // Wrap sets OVF after two clocks from 0xFFFFFFFE.
    force dut.r_cycles = 32'hFFFFFFFE;
    release dut.r_cycles;
    @(negedge clk_i); @(negedge clk_i);
    rd_chk("ovf_set", 5'h18, 32'h2);
    wr(5'h18, 32'h2, 4'b0001);
    rd_chk("ovf_clr", 5'h18, 32'h0);

    // Wrap in the same clock as a write-1 clear: OVF stays set.
    force dut.r_cycles = 32'hFFFFFFFF;
    release dut.r_cycles;
    wr(5'h18, 32'h2, 4'b0001);
    rd_chk("ovf_beats_clr", 5'h18, 32'h2);
    wr(5'h18, 32'h2, 4'b0001);
    rd_chk("ovf_clr2", 5'h18, 32'h0);

    // CCLR in the wrapping clock: no overflow.
    force dut.r_cycles = 32'hFFFFFFFF;
    release dut.r_cycles;
    wr(5'h0C, 32'h3, 4'b0001);
    rd_chk("cclr_no_ovf", 5'h18, 32'h0);
    wr(5'h0C, 32'h0, 4'b0001);
    check("run_off", {31'd0, run_o}, 32'd0);

    // Five event pulses, each 3 clocks high and 3 low.
    for (int p = 0; p < 5; p++) begin
      event_i = 1'b1; repeat (3) @(negedge clk_i);
      event_i = 1'b0; repeat (3) @(negedge clk_i);
    end
    repeat (4) @(negedge clk_i);
    rd_chk("events5", 5'h14, 32'd5);

    // ECLR recognized on the edge where the synchronized rise is counted.
    event_i = 1'b1;
    @(negedge clk_i); @(negedge clk_i);
    wr(5'h0C, 32'h4, 4'b0001);
    rd_chk("eclr_wins", 5'h14, 32'd0);
    rd_chk("status_lvl", 5'h18, 32'h1);
    event_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Unmapped word: error termination, no data, no side effects.
    wb(1'b0, 5'h1C, 32'h0, 4'hF, rd, ak, er, ta);
    check("unm_rd_err", {31'd0, er}, 32'd1);
    check("unm_rd_ack", {31'd0, ak}, 32'd0);
    check("unm_rd_dat", rd, 32'd0);
    check("unm_rd_single", {31'd0, ta}, 32'd0);
    wb(1'b1, 5'h1C, 32'hFFFFFFFF, 4'hF, rd, ak, er, ta);
    check("unm_wr_err", {31'd0, er}, 32'd1);
    check("unm_wr_ack", {31'd0, ak}, 32'd0);
    rd_chk("unm_no_change", 5'h08, 32'hDE00BE00);

    // Strobe held for four clocks: terminations at N and N+2 only.
    terms = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 5'h08;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (ack_o || err_o) terms++;
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    check("held_stb_terms", terms, 32'd2);

    // Asynchronous reset while ack is high.
    wr(5'h0C, 32'h1, 4'b0001);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 5'h08;
    @(posedge clk_i); #1;
    check("pre_rst_ack", {31'd0, ack_o}, 32'd1);
    rst_n_i = 1'b0; #1;
    check("rst_async_ack", {31'd0, ack_o}, 32'd0);
    check("rst_async_run", {31'd0, run_o}, 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    rd_chk("scr_after_rst", 5'h08, 32'h0);
    check("run_after_rst", {31'd0, run_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
